// File: rtl/udm_uart_pkg.sv
// Shared UDM UART definitions: receiver FSM encoding, frame geometry and the
// UDM control byte values used by the controller and the TX stage.
package udm_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int DIV_MIN        = 8;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam logic [7:0] ESCAPE_BYTE = 8'h5a;

endpackage

// File: rtl/udm_uart_rx_if.sv
// Receive-side handshake between udm_uart_rx (master) and the UDM bus-master
// controller (slave). parity_err_o exists only when UDM_UART_RX_PARITY_EN is
// defined.
interface udm_uart_rx_if;

  logic       rx_done_tick_o;
  logic [7:0] rx_dout_bo;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UDM_UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

`ifdef UDM_UART_RX_PARITY_EN
  modport master (
    output rx_done_tick_o,
    output rx_dout_bo,
    output frame_err_o,
    output busy_o,
    output parity_err_o
  );

  modport slave (
    input rx_done_tick_o,
    input rx_dout_bo,
    input frame_err_o,
    input busy_o,
    input parity_err_o
  );
`else
  modport master (
    output rx_done_tick_o,
    output rx_dout_bo,
    output frame_err_o,
    output busy_o
  );

  modport slave (
    input rx_done_tick_o,
    input rx_dout_bo,
    input frame_err_o,
    input busy_o
  );
`endif

endinterface

// File: rtl/udm_sync_ff.sv
// Reset-to-1 flop chain bringing an asynchronous, idle-high line into the
// clk_i domain. Reused for every async input of the UDM front end.
module udm_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  // Shift the async input through the chain; reset holds the line idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/udm_uart_rx.sv
// UART receiver feeding the UDM bus-master controller. Deserialises 8N1
// frames (8E1 when UDM_UART_RX_PARITY_EN is defined) with a runtime baud
// divisor and reports each byte as a one-cycle tick plus held data.
module udm_uart_rx
  import udm_uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_bi,
  udm_uart_rx_if.master        rx_if
);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_sel;
  logic [DIV_WIDTH-1:0] half_m1;
  logic [DIV_WIDTH-1:0] full_m1;
  logic [7:0]           shreg_q;
  logic [2:0]           bitn_q;
  logic [7:0]           dout_q;
  logic                 tick_q;
  logic                 ferr_q;
  logic                 start_mid;
  logic                 bit_end;
  logic                 last_bit;
  logic                 par_bad;

  logic                 cnt_clr;
  logic                 shift_en;
  logic                 div_load;
  logic                 tick_d;
  logic                 ferr_d;
  logic                 perr_d;
  logic                 busy;

  udm_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_rx (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (rx_i),
    .q_o       (rxs)
  );

  // Divisors below the minimum cannot place a mid-bit sample; clamp them.
  assign div_sel   = (baud_div_bi < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : baud_div_bi;
  assign half_m1   = (div_q >> 1) - DIV_WIDTH'(1);
  assign full_m1   = div_q - DIV_WIDTH'(1);
  assign start_mid = (cnt_q == half_m1);
  assign bit_end   = (cnt_q == full_m1);
  assign last_bit  = (bitn_q == 3'(UART_DATA_BITS - 1));

`ifdef UDM_UART_RX_PARITY_EN
  logic par_q;
  logic perr_q;

  // Even parity: the sampled bit must equal the XOR of the data bits.
  assign par_bad = (par_q != ^shreg_q);
`else
  assign par_bad = 1'b0;
  assign perr_d  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every decision looks at the synchronised line only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rxs) state_d = START;
      START:  if (start_mid) state_d = rxs ? IDLE : DATA;
`ifdef UDM_UART_RX_PARITY_EN
      DATA:   if (bit_end && last_bit) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && last_bit) state_d = STOP;
`endif
      STOP:   if (bit_end) state_d = rxs ? IDLE : BREAK;
      BREAK:  if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath strobes derived from the current state.
  always_comb begin
    busy     = (state_q != IDLE);
    div_load = (state_q == IDLE) && (state_d == START);
    shift_en = (state_q == DATA) && bit_end;
    // Counter restarts on every state entry and after each data sample;
    // it is held at zero while waiting in IDLE or BREAK.
    cnt_clr  = (state_d != state_q) || shift_en ||
               (state_q == IDLE) || (state_q == BREAK);
    tick_d   = (state_q == STOP) && bit_end && rxs && !par_bad;
    ferr_d   = (state_q == STOP) && bit_end && !rxs;
`ifdef UDM_UART_RX_PARITY_EN
    // A frame error masks the parity error.
    perr_d   = (state_q == STOP) && bit_end && rxs && par_bad;
`endif
  end

  // Bit timing, deserialisation and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(DIV_MIN);
      shreg_q <= 8'h00;
      bitn_q  <= 3'd0;
      dout_q  <= 8'h00;
      tick_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + DIV_WIDTH'(1);
      if (div_load) begin
        div_q <= div_sel;
      end
      if (state_q == IDLE) begin
        bitn_q <= 3'd0;
      end else if (shift_en) begin
        shreg_q <= {rxs, shreg_q[7:1]};
        bitn_q  <= bitn_q + 3'd1;
      end
      if (tick_d) begin
        dout_q <= shreg_q;
      end
      tick_q <= tick_d;
      ferr_q <= ferr_d;
    end
  end

`ifdef UDM_UART_RX_PARITY_EN
  // Parity bit capture and parity-error pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if ((state_q == PARITY) && bit_end) begin
        par_q <= rxs;
      end
      perr_q <= perr_d;
    end
  end

  assign rx_if.parity_err_o = perr_q;
`endif

  assign rx_if.rx_done_tick_o = tick_q;
  assign rx_if.rx_dout_bo     = dout_q;
  assign rx_if.frame_err_o    = ferr_q;
  assign rx_if.busy_o         = busy;

endmodule

// File: tb/tb_udm_uart_rx.sv
// Directed bench for udm_uart_rx. Build with UDM_UART_RX_PARITY_EN defined to
// also exercise the 8E1 parity path.
module tb_udm_uart_rx;
  import udm_uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] baud;

  int errors = 0;
  int checks = 0;

  int          cyc       = 0;
  int          tick_cnt  = 0;
  int          ferr_cnt  = 0;
  int          perr_cnt  = 0;
  int          both_cnt  = 0;
  logic        tick_prev = 1'b0;
  logic        busy_after = 1'b1;
  logic [7:0]  tick_dat[$];
  int          tick_cyc[$];

  udm_uart_rx_if u_if();

  udm_uart_rx #(
    .DIV_WIDTH   (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .rx_i        (rx),
    .baud_div_bi (baud),
    .rx_if       (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    tick_prev <= u_if.rx_done_tick_o;
    if (tick_prev) busy_after <= u_if.busy_o;
    if (u_if.rx_done_tick_o) begin
      tick_cnt <= tick_cnt + 1;
      tick_dat.push_back(u_if.rx_dout_bo);
      tick_cyc.push_back(cyc);
    end
    if (u_if.frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (u_if.rx_done_tick_o && u_if.frame_err_o) both_cnt <= both_cnt + 1;
`ifdef UDM_UART_RX_PARITY_EN
    if (u_if.parity_err_o) perr_cnt <= perr_cnt + 1;
    if (u_if.rx_done_tick_o && u_if.parity_err_o) both_cnt <= both_cnt + 1;
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within 200000 ns");
    $fatal(1);
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic par_on, input logic par_v);
    int n;
    n = int'(baud);
    hold(1'b0, n);
    for (int i = 0; i < 8; i++) hold(d[i], n);
    if (par_on) hold(par_v, n);
    hold(stop_v, n);
  endtask

  function automatic logic [7:0] dat_at(input int idx);
    if (tick_dat.size() > idx) return tick_dat[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    baud  = 16'd16;
    repeat (2) @(negedge clk);
    checks++; if (u_if.rx_done_tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", u_if.rx_done_tick_o); end
    checks++; if (u_if.rx_dout_bo !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", u_if.rx_dout_bo); end
    checks++; if (u_if.frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", u_if.frame_err_o); end
    checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy_o); end
    rst_n = 1'b1;
    hold(1'b1, 5);
  endtask

  task automatic test_single;
    int t0, f0;
    t0 = tick_cnt; f0 = ferr_cnt;
    send_frame(SYNC_BYTE, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL single_ticks: got %0d want 1", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h55) begin errors++; $display("FAIL single_dout: got %h want 55", u_if.rx_dout_bo); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after_tick: got %b want 0", busy_after); end
  endtask

  task automatic test_back_to_back;
    int t0, sp;
    t0 = tick_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(ESCAPE_BYTE, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 2) begin errors++; $display("FAIL b2b_ticks: got %0d want 2", tick_cnt - t0); end
    checks++; if (dat_at(t0) !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h want a5", dat_at(t0)); end
    checks++; if (dat_at(t0 + 1) !== 8'h5A) begin errors++; $display("FAIL b2b_second: got %h want 5a", dat_at(t0 + 1)); end
    sp = (tick_cyc.size() > t0 + 1) ? tick_cyc[t0 + 1] - tick_cyc[t0] : -1;
    checks++; if (sp < 159 || sp > 161) begin errors++; $display("FAIL b2b_spacing: got %0d want 160+-1", sp); end
  endtask

  task automatic test_glitch;
    int t0, f0;
    t0 = tick_cnt; f0 = ferr_cnt;
    hold(1'b0, 5);
    hold(1'b1, 40);
    checks++; if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL glitch_ticks: got %0d want 0", tick_cnt - t0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %b want 0", u_if.busy_o); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL glitch_next_ticks: got %0d want 1", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h3C) begin errors++; $display("FAIL glitch_next_dout: got %h want 3c", u_if.rx_dout_bo); end
  endtask

  task automatic test_frame_err;
    int t0, f0;
    t0 = tick_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 50);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
    checks++; if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL ferr_ticks: got %0d want 0", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h3C) begin errors++; $display("FAIL ferr_dout_kept: got %h want 3c", u_if.rx_dout_bo); end
    checks++; if (u_if.busy_o !== 1'b1) begin errors++; $display("FAIL ferr_break_held: busy got %b want 1", u_if.busy_o); end
    hold(1'b1, 20);
    checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL ferr_break_release: busy got %b want 0", u_if.busy_o); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_no_extra: got %0d want 1", ferr_cnt - f0); end
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL ferr_next_ticks: got %0d want 1", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h00) begin errors++; $display("FAIL ferr_next_dout: got %h want 00", u_if.rx_dout_bo); end
  endtask

  task automatic test_async_reset;
    int t0, f0;
    t0 = tick_cnt; f0 = ferr_cnt;
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(1'b1, 16);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (u_if.busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", u_if.busy_o); end
    checks++; if (u_if.rx_dout_bo !== 8'h00) begin errors++; $display("FAIL areset_dout: got %h want 00", u_if.rx_dout_bo); end
    checks++; if (u_if.rx_done_tick_o !== 1'b0) begin errors++; $display("FAIL areset_tick: got %b want 0", u_if.rx_done_tick_o); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 200);
    checks++; if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL areset_no_tick: got %0d want 0", tick_cnt - t0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL areset_no_ferr: got %0d want 0", ferr_cnt - f0); end
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL areset_next_ticks: got %0d want 1", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h12) begin errors++; $display("FAIL areset_next_dout: got %h want 12", u_if.rx_dout_bo); end
  endtask

`ifdef UDM_UART_RX_PARITY_EN
  task automatic test_parity;
    int t0, p0;
    baud = 16'd8;
    hold(1'b1, 10);
    t0 = tick_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_bad_pulses: got %0d want 1", perr_cnt - p0); end
    checks++; if (tick_cnt - t0 !== 0) begin errors++; $display("FAIL par_bad_ticks: got %0d want 0", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h12) begin errors++; $display("FAIL par_bad_dout_kept: got %h want 12", u_if.rx_dout_bo); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 20);
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL par_good_ticks: got %0d want 1", tick_cnt - t0); end
    checks++; if (u_if.rx_dout_bo !== 8'h07) begin errors++; $display("FAIL par_good_dout: got %h want 07", u_if.rx_dout_bo); end
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_good_no_err: got %0d want 1", perr_cnt - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_async_reset();
`ifdef UDM_UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
